// File: rtl/y86_pkg.sv
// Shared Y86 sequential-core definitions: stage encoding, icode and status constants.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package y86_pkg;

    // Stage encoding is visible on the stage output, so the order is fixed.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WRBACK  = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instructions that touch data memory and therefore visit MEMORY.
    function automatic logic uses_mem(input logic [3:0] ic);
        logic m;
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: m = 1'b1;
            default:                                           m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_next_pc_sel.sv
// Next-PC select: chooses the PC loaded in PCUPD from icode/Cnd and valP/valC/valM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the value is only consumed while the controller sits in PCUPD.
// Ports: icode, Cnd, valP, valC, valM in; next_pc out.
module next_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic [63:0] valP,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    output logic [63:0] next_pc
);

    always_comb begin
        next_pc = valP;
        case (icode)
            I_JXX:   next_pc = Cnd ? valC : valP;
            I_CALL:  next_pc = valC;
            I_RET:   next_pc = valM;
            default: next_pc = valP;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential Y86 stage controller: walks FETCH..PCUPD per instruction, owns PC and status.
// Latency: 5 cycles/instruction without MEMORY, 6 with it, plus any imem/dmem ack wait.
// Backpressure: FETCH holds imem_req until imem_ack, MEMORY holds dmem_req until dmem_ack.
// Ports: clk, rst_n (async, active low); start; icode, Cnd, valP/valC/valM, instr_valid,
//        imem_error, dmem_error; imem_req/imem_ack, dmem_req/dmem_ack; PC, stage, rf_we,
//        stat, halted. With SEQ_CYCLE_CNT_EN defined also cycle_cnt and insn_cnt.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic [63:0] valP,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [63:0] PC,
    output logic [2:0]  stage,
    output logic        rf_we,
`ifdef SEQ_CYCLE_CNT_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] insn_cnt,
`endif
    output logic [2:0]  stat,
    output logic        halted
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  stat_d;
    logic [63:0] next_pc;

    next_pc_sel u_next_pc_sel (
        .icode   (icode),
        .Cnd     (Cnd),
        .valP    (valP),
        .valC    (valC),
        .valM    (valM),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat    <= STAT_AOK;
            PC      <= RESET_PC;
        end else begin
            state_q <= state_d;
            stat    <= stat_d;
            if (state_q == S_PCUPD) begin
                PC <= next_pc;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        stat_d   = stat;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // Fault priority: address fault, then illegal, then halt.
                if (imem_ack) begin
                    if (imem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (!instr_valid) begin
                        stat_d  = STAT_INS;
                        state_d = S_HALT;
                    end else if (icode == I_HALT) begin
                        stat_d  = STAT_HLT;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = uses_mem(icode) ? S_MEMORY : S_WRBACK;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRBACK;
                    end
                end
            end
            S_WRBACK: begin
                rf_we   = (stat == STAT_AOK);
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stage  = state_q;
    assign halted = (state_q == S_HALT);

`ifdef SEQ_CYCLE_CNT_EN
    // cycle_cnt counts every cycle spent working on an instruction; insn_cnt counts retirements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 64'd0;
            insn_cnt  <= 64'd0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (state_q == S_PCUPD) begin
                insn_cnt <= insn_cnt + 64'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
